// File: rtl/mcp_controller_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface mcp_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
           alusrcb, pcsrc, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
           alusrcb, pcsrc, alucontrol
  );
endinterface

// File: rtl/mcp_controller.sv
// Multicycle MIPS control unit: Moore main FSM plus combinational ALU decoder.
// Optional feature macro: MCP_CTRL_BNE_EN adds the BNE instruction.
module mcp_controller (
  input  logic              clk,
  input  logic              reset,
  mcp_controller_if.master  bus
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCP_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;
`ifdef MCP_CTRL_BNE_EN
  localparam logic [3:0] BNEEX   = 4'd12;
`endif

  logic [3:0] state, state_nxt;
  logic       pcwrite, branch;
  logic [1:0] aluop;
`ifdef MCP_CTRL_BNE_EN
  logic       bne;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Unknown opcodes and unreachable state codes both fall back to FETCH.
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:   state_nxt = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = RTYPEEX;
          OP_BEQ:       state_nxt = BEQEX;
          OP_ADDI:      state_nxt = ADDIEX;
          OP_J:         state_nxt = JEX;
`ifdef MCP_CTRL_BNE_EN
          OP_BNE:       state_nxt = BNEEX;
`endif
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR:  state_nxt = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_nxt = MEMWB;
      RTYPEEX: state_nxt = RTYPEWB;
      ADDIEX:  state_nxt = ADDIWB;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = 2'b00;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca  = 1'b0;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
`ifdef MCP_CTRL_BNE_EN
    bne          = 1'b0;
`endif
    case (state)
      DECODE:  bus.alusrcb = 2'b11;
      MEMADR:  begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; end
      MEMRD:   bus.iord = 1'b1;
      MEMWB:   begin bus.regwrite = 1'b1; bus.memtoreg = 1'b1; end
      MEMWR:   begin bus.iord = 1'b1; bus.memwrite = 1'b1; end
      RTYPEEX: begin bus.alusrca = 1'b1; aluop = 2'b10; end
      RTYPEWB: begin bus.regwrite = 1'b1; bus.regdst = 1'b1; end
      BEQEX:   begin bus.alusrca = 1'b1; aluop = 2'b01; bus.pcsrc = 2'b01; branch = 1'b1; end
      ADDIEX:  begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; end
      ADDIWB:  bus.regwrite = 1'b1;
      JEX:     begin bus.pcsrc = 2'b10; pcwrite = 1'b1; end
`ifdef MCP_CTRL_BNE_EN
      BNEEX:   begin bus.alusrca = 1'b1; aluop = 2'b01; bus.pcsrc = 2'b01; bne = 1'b1; end
`endif
      default: begin bus.irwrite = 1'b1; pcwrite = 1'b1; bus.alusrcb = 2'b01; end
    endcase
  end

`ifdef MCP_CTRL_BNE_EN
  assign bus.pcen = pcwrite | (branch & bus.zero) | (bne & ~bus.zero);
`else
  assign bus.pcen = pcwrite | (branch & bus.zero);
`endif

  always_comb begin
    bus.alucontrol = 3'b010;
    case (aluop)
      2'b01: bus.alucontrol = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100010: bus.alucontrol = 3'b110;
          6'b100100: bus.alucontrol = 3'b000;
          6'b100101: bus.alucontrol = 3'b001;
          6'b101010: bus.alucontrol = 3'b111;
          default:   bus.alucontrol = 3'b010;
        endcase
      end
      default: bus.alucontrol = 3'b010;
    endcase
  end

endmodule

// File: tb/tb_mcp_controller.sv
// Bench for mcp_controller: directed scenarios plus randomized instructions vs a phase-level model.
module tb_mcp_controller;

  typedef string phase_q_t[$];

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mcp_controller_if bus ();

  mcp_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic logic [14:0] obs();
    return {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.alusrca, bus.iord,
            bus.memtoreg, bus.regdst, bus.alusrcb, bus.pcsrc, bus.alucontrol};
  endfunction

  // Reference model: instruction -> list of phases, phase -> control word.
  function automatic phase_q_t phases(input logic [5:0] op);
    phase_q_t q;
    q = {"FETCH", "DECODE"};
    case (op)
      6'b100011: q = {q, "MEMADR", "MEMRD", "MEMWB"};
      6'b101011: q = {q, "MEMADR", "MEMWR"};
      6'b000000: q = {q, "RTYPEEX", "RTYPEWB"};
      6'b000100: q = {q, "BEQEX"};
      6'b001000: q = {q, "ADDIEX", "ADDIWB"};
      6'b000010: q = {q, "JEX"};
`ifdef MCP_CTRL_BNE_EN
      6'b000101: q = {q, "BNEEX"};
`endif
      default: ;
    endcase
    return q;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [1:0] aop, input logic [5:0] fn);
    if (aop == 2'b01) return 3'b110;
    if (aop != 2'b10) return 3'b010;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [14:0] exp_vec(input string ph, input logic [5:0] fn, input logic z);
    logic pcw, br, bn, mw, irw, rw, asa, io, m2r, rd, pcen;
    logic [1:0] asb, ps, aop;
    {pcw, br, bn, mw, irw, rw, asa, io, m2r, rd} = '0;
    asb = 2'b00; ps = 2'b00; aop = 2'b00;
    case (ph)
      "FETCH":   begin irw = 1; pcw = 1; asb = 2'b01; end
      "DECODE":  asb = 2'b11;
      "MEMADR":  begin asa = 1; asb = 2'b10; end
      "MEMRD":   io = 1;
      "MEMWB":   begin rw = 1; m2r = 1; end
      "MEMWR":   begin io = 1; mw = 1; end
      "RTYPEEX": begin asa = 1; aop = 2'b10; end
      "RTYPEWB": begin rw = 1; rd = 1; end
      "BEQEX":   begin asa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
      "ADDIEX":  begin asa = 1; asb = 2'b10; end
      "ADDIWB":  rw = 1;
      "JEX":     begin ps = 2'b10; pcw = 1; end
      "BNEEX":   begin asa = 1; aop = 2'b01; ps = 2'b01; bn = 1; end
      default: ;
    endcase
    pcen = pcw | (br & z) | (bn & ~z);
    return {pcen, mw, irw, rw, asa, io, m2r, rd, asb, ps, alu_ref(aop, fn)};
  endfunction

  function automatic logic [5:0] rand_funct();
    case ($urandom_range(0, 5))
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.op = 6'b111111; bus.funct = 6'b100000; bus.zero = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 15'h5022) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs(), 15'h5022); end
    tick(); tick();
    n_checks++;
    if (obs() !== 15'h5022) begin n_fail++; $display("FAIL reset_clocked: got %h want %h", obs(), 15'h5022); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 15'h5022) begin n_fail++; $display("FAIL reset_release: got %h want %h", obs(), 15'h5022); end
    tick();
    n_checks++;
    if (obs() !== 15'h0062) begin n_fail++; $display("FAIL decode_after_reset: got %h want %h", obs(), 15'h0062); end
    tick();
    n_checks++;
    if (obs() !== 15'h5022) begin n_fail++; $display("FAIL unknown_op_to_fetch: got %h want %h", obs(), 15'h5022); end
  endtask

  task automatic test_sw();
    bus.op = 6'b101011;
    tick();
    tick();
    n_checks++;
    if (obs() !== 15'h0442) begin n_fail++; $display("FAIL sw_memadr: got %h want %h", obs(), 15'h0442); end
    tick();
    n_checks++;
    if (obs() !== 15'h2202) begin n_fail++; $display("FAIL sw_memwr: got %h want %h", obs(), 15'h2202); end
    tick();
    n_checks++;
    if (obs() !== 15'h5022) begin n_fail++; $display("FAIL sw_back_to_fetch: got %h want %h", obs(), 15'h5022); end
  endtask

  task automatic test_rtype();
    bus.op = 6'b000000; bus.funct = 6'b100010;
    tick();
    tick();
    n_checks++;
    if (obs() !== 15'h0406) begin n_fail++; $display("FAIL rtype_ex_sub: got %h want %h", obs(), 15'h0406); end
    bus.funct = 6'b101010;
    #1;
    n_checks++;
    if (bus.alucontrol !== 3'b111) begin n_fail++; $display("FAIL rtype_ex_slt_comb: got %b want %b", bus.alucontrol, 3'b111); end
    bus.funct = 6'b100010;
    tick();
    n_checks++;
    if (obs() !== 15'h0882) begin n_fail++; $display("FAIL rtype_wb: got %h want %h", obs(), 15'h0882); end
    tick();
  endtask

  task automatic test_beq_j();
    bus.op = 6'b000100; bus.zero = 1'b1;
    tick();
    tick();
    n_checks++;
    if (obs() !== 15'h440E) begin n_fail++; $display("FAIL beq_zero1: got %h want %h", obs(), 15'h440E); end
    bus.zero = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 15'h040E) begin n_fail++; $display("FAIL beq_zero0: got %h want %h", obs(), 15'h040E); end
    tick();
    n_checks++;
    if (obs() !== 15'h5022) begin n_fail++; $display("FAIL beq_to_fetch: got %h want %h", obs(), 15'h5022); end
    bus.op = 6'b000010;
    tick();
    tick();
    n_checks++;
    if (obs() !== 15'h4012) begin n_fail++; $display("FAIL j_jex: got %h want %h", obs(), 15'h4012); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.op = 6'b100011;
    tick();
    tick();
    tick();
    n_checks++;
    if (obs() !== 15'h0202) begin n_fail++; $display("FAIL lw_memrd: got %h want %h", obs(), 15'h0202); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 15'h5022) begin n_fail++; $display("FAIL async_reset_memrd: got %h want %h", obs(), 15'h5022); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 15'h5022) begin n_fail++; $display("FAIL after_abort_fetch: got %h want %h", obs(), 15'h5022); end
  endtask

  task automatic test_random();
    phase_q_t q;
    logic [5:0] op;
    logic [14:0] want;
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 7))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        6: op = 6'b000101;
        default: op = 6'($urandom);
      endcase
      bus.op = op;
      q = phases(op);
      foreach (q[i]) begin
        for (int s = 0; s < 2; s++) begin
          bus.funct = rand_funct();
          bus.zero  = 1'($urandom_range(0, 1));
          #1;
          want = exp_vec(q[i], bus.funct, bus.zero);
          n_checks++;
          if (obs() !== want) begin
            n_fail++;
            $display("FAIL rand_%s op=%b: got %h want %h", q[i], op, obs(), want);
          end
        end
        tick();
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sw();
    test_rtype();
    test_beq_j();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
